// File: rtl/mem_wb_queue.sv
// mem_wb_queue: in-order memory-operation queue between issue and the data bus.
//
// Committed loads/stores are allocated at the tail and presented to the bus
// one at a time in allocation order. Responses come back in the same order.
// Each response retires the oldest outstanding entry and produces a registered
// writeback (mem_sel/mem_data/mem_release) one cycle later.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_vld/in_rdy     allocate handshake (in_rdy depends on registered count only)
//   in_store, in_rd, in_size, in_unsigned, in_addr, in_wdata   op description
//   bus_req/bus_ack   request handshake; bus_we/addr/be/wdata describe it
//   bus_rvld/rdata    in-order response (loads and stores)
//   mem_sel/mem_data  writeback register and extended load data
//   mem_release       ops retired this cycle (0 or 1)
//   mem_pending       occupied entries (unissued + outstanding)
module mem_wb_queue #(
  parameter int DEPTH   = 4,
  parameter int RGBIT   = 5,
  parameter int MEM_OFF = 2,
  parameter int XLEN    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic                     in_store,
  input  logic [RGBIT-1:0]         in_rd,
  input  logic [1:0]               in_size,
  input  logic                     in_unsigned,
  input  logic [XLEN-1:0]          in_addr,
  input  logic [XLEN-1:0]          in_wdata,
  output logic                     bus_req,
  input  logic                     bus_ack,
  output logic                     bus_we,
  output logic [XLEN-1:0]          bus_addr,
  output logic [3:0]               bus_be,
  output logic [XLEN-1:0]          bus_wdata,
  input  logic                     bus_rvld,
  input  logic [XLEN-1:0]          bus_rdata,
  output logic [RGBIT-1:0]         mem_sel,
  output logic [XLEN-1:0]          mem_data,
  output logic [MEM_OFF-1:0]       mem_release,
  output logic [$clog2(DEPTH):0]   mem_pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Entry storage (data only, no reset needed)
  logic             r_store [DEPTH];
  logic [RGBIT-1:0] r_rd    [DEPTH];
  logic [1:0]       r_size  [DEPTH];
  logic             r_uns   [DEPTH];
  logic [XLEN-1:0]  r_addr  [DEPTH];
  logic [XLEN-1:0]  r_wdata [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_iss_ptr;
  logic [PW-1:0]    r_ret_ptr;
  logic [PW-1:0]    r_count;

  logic             r_rel;
  logic [RGBIT-1:0] r_sel;
  logic [XLEN-1:0]  r_data;

  logic             w_alloc;
  logic             w_bus_req;
  logic             w_issue;
  logic             w_ret;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_iss_idx;
  logic [AW-1:0]    w_ret_idx;
  logic [1:0]       w_iss_off;
  logic [1:0]       w_ret_off;
  logic [3:0]       w_mask;
  logic [XLEN-1:0]  w_rshift;
  logic [XLEN-1:0]  w_ext;

  assign w_wr_idx  = r_wr_ptr[AW-1:0];
  assign w_iss_idx = r_iss_ptr[AW-1:0];
  assign w_ret_idx = r_ret_ptr[AW-1:0];

  assign in_rdy    = (r_count < PW'(DEPTH));
  assign w_alloc   = in_vld & in_rdy;
  assign w_bus_req = (r_iss_ptr != r_wr_ptr);
  assign w_issue   = w_bus_req & bus_ack;
  // Only entries already on the bus can retire; a stray response is dropped
  assign w_ret     = bus_rvld & (r_ret_ptr != r_iss_ptr);

  assign w_iss_off = r_addr[w_iss_idx][1:0];
  assign w_ret_off = r_addr[w_ret_idx][1:0];

  always_comb begin
    w_mask = 4'b1111;
    case (r_size[w_iss_idx])
      2'd0:    w_mask = 4'b0001;
      2'd1:    w_mask = 4'b0011;
      default: w_mask = 4'b1111;
    endcase
  end

  // Bus fields are forced to zero when nothing is pending so idle outputs are clean
  assign bus_req   = w_bus_req;
  assign bus_we    = w_bus_req & r_store[w_iss_idx];
  assign bus_addr  = w_bus_req ? {r_addr[w_iss_idx][XLEN-1:2], 2'b00} : '0;
  assign bus_be    = w_bus_req ? 4'(w_mask << w_iss_off) : 4'b0000;
  assign bus_wdata = w_bus_req ? (r_wdata[w_iss_idx] << {w_iss_off, 3'b000}) : '0;

  assign w_rshift  = bus_rdata >> {w_ret_off, 3'b000};

  always_comb begin
    w_ext = w_rshift;
    case (r_size[w_ret_idx])
      2'd0: w_ext = r_uns[w_ret_idx] ? {{(XLEN-8){1'b0}}, w_rshift[7:0]}
                                     : {{(XLEN-8){w_rshift[7]}}, w_rshift[7:0]};
      2'd1: w_ext = r_uns[w_ret_idx] ? {{(XLEN-16){1'b0}}, w_rshift[15:0]}
                                     : {{(XLEN-16){w_rshift[15]}}, w_rshift[15:0]};
      default: w_ext = w_rshift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_alloc && !rst) begin
      r_store[w_wr_idx] <= in_store;
      r_rd[w_wr_idx]    <= in_rd;
      r_size[w_wr_idx]  <= in_size;
      r_uns[w_wr_idx]   <= in_unsigned;
      r_addr[w_wr_idx]  <= in_addr;
      r_wdata[w_wr_idx] <= in_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_iss_ptr <= '0;
      r_ret_ptr <= '0;
      r_count   <= '0;
    end else begin
      if (w_alloc) r_wr_ptr  <= r_wr_ptr + PW'(1);
      if (w_issue) r_iss_ptr <= r_iss_ptr + PW'(1);
      if (w_ret)   r_ret_ptr <= r_ret_ptr + PW'(1);
      r_count <= r_count + PW'(w_alloc) - PW'(w_ret);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rel  <= 1'b0;
      r_sel  <= '0;
      r_data <= '0;
    end else begin
      r_rel  <= w_ret;
      r_sel  <= (w_ret && !r_store[w_ret_idx]) ? r_rd[w_ret_idx] : '0;
      r_data <= (w_ret && !r_store[w_ret_idx]) ? w_ext : '0;
    end
  end

  assign mem_sel     = r_sel;
  assign mem_data    = r_data;
  assign mem_release = MEM_OFF'(r_rel);
  assign mem_pending = r_count;

endmodule
